dds_tone_scheduler: RTL and testbench



---
 rtl/dds_tone_scheduler.sv | 172 +++++++++++++++++
 tb/tb_dds_tone_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_tone_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dds_tone_scheduler                                            |
// | Purpose  : Round-robin tone-burst scheduler driving a shared sine LUT.   |
// |            Optional abort support under `DDS_SCHED_ABORT_EN.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dds_tone_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_step,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
`ifdef DDS_SCHED_ABORT_EN
  input  logic                      abort,
  output logic                      aborted,
`endif
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [ADDR_W-1:0]         lut_addr,
  output logic                      lut_valid,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [ADDR_W-1:0] r_phase;
  logic [ADDR_W-1:0] r_step;
  logic [LEN_W-1:0]  r_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic               w_found;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [ADDR_W-1:0]  w_win_step;
  logic [LEN_W-1:0]   w_win_len;
  logic               w_end;
  logic               w_launch;

  // Two passes: requesters at or above the pointer first, then the wrap-around.
  always_comb begin
    w_found    = 1'b0;
    w_win_oh   = '0;
    w_next_ptr = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req[j] && (j >= int'(r_ptr))) begin
        w_found     = 1'b1;
        w_win_oh[j] = 1'b1;
        w_next_ptr  = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req[j]) begin
        w_found     = 1'b1;
        w_win_oh[j] = 1'b1;
        w_next_ptr  = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  always_comb begin
    w_win_step = '0;
    w_win_len  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win_oh[j]) begin
        w_win_step = req_step[j*ADDR_W +: ADDR_W];
        w_win_len  = req_len[j*LEN_W +: LEN_W];
      end
    end
  end

  // r_cnt holds samples remaining including the one on lut_addr now.
`ifdef DDS_SCHED_ABORT_EN
  assign w_end = (r_cnt <= LEN_W'(1)) || abort;
`else
  assign w_end = (r_cnt <= LEN_W'(1));
`endif

  assign w_launch = w_found &&
                    ((r_state == ST_IDLE) ||
                     ((r_state == ST_RUN) && w_end && (GAP_CYCLES == 0)));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_phase   <= '0;
      r_step    <= '0;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
      grant     <= '0;
      done      <= '0;
      lut_addr  <= '0;
      lut_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef DDS_SCHED_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      done <= '0;
`ifdef DDS_SCHED_ABORT_EN
      aborted <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: ;
        ST_RUN: begin
          if (w_end) begin
            done      <= grant;
            grant     <= '0;
            lut_valid <= 1'b0;
            lut_addr  <= '0;
`ifdef DDS_SCHED_ABORT_EN
            aborted   <= abort;
`endif
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state   <= ST_GAP;
              r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end
          end else begin
            lut_addr <= r_phase;
            r_phase  <= r_phase + r_step;
            r_cnt    <= r_cnt - LEN_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase

      // Launch overrides the RUN-exit assignments when GAP_CYCLES is zero.
      if (w_launch) begin
        r_state   <= ST_RUN;
        busy      <= 1'b1;
        grant     <= w_win_oh;
        r_ptr     <= w_next_ptr;
        r_step    <= w_win_step;
        r_phase   <= w_win_step;
        r_cnt     <= w_win_len;
        lut_addr  <= '0;
        lut_valid <= (w_win_len != '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_tone_scheduler.sv
`default_nettype none
// Bench for dds_tone_scheduler: one instance with GAP_CYCLES=2, one with GAP_CYCLES=0.
module tb_dds_tone_scheduler;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int LW = 16;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic [N-1:0]    a_req, a_grant, a_done;
  logic [N*AW-1:0] a_step;
  logic [N*LW-1:0] a_len;
  logic [AW-1:0]   a_addr;
  logic            a_valid, a_busy;
  logic [N-1:0]    b_req, b_grant, b_done;
  logic [N*AW-1:0] b_step;
  logic [N*LW-1:0] b_len;
  logic [AW-1:0]   b_addr;
  logic            b_valid, b_busy;
`ifdef DDS_SCHED_ABORT_EN
  logic a_abort = 1'b0, a_aborted, b_abort = 1'b0, b_aborted;
`endif

  int checks = 0;
  int errors = 0;

  dds_tone_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .GAP_CYCLES(2)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(a_req), .req_step(a_step), .req_len(a_len),
`ifdef DDS_SCHED_ABORT_EN
    .abort(a_abort), .aborted(a_aborted),
`endif
    .grant(a_grant), .done(a_done), .lut_addr(a_addr), .lut_valid(a_valid), .busy(a_busy)
  );

  dds_tone_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .GAP_CYCLES(0)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(b_req), .req_step(b_step), .req_len(b_len),
`ifdef DDS_SCHED_ABORT_EN
    .abort(b_abort), .aborted(b_aborted),
`endif
    .grant(b_grant), .done(b_done), .lut_addr(b_addr), .lut_valid(b_valid), .busy(b_busy)
  );

  task automatic wait_a_idle(input string name);
    int n = 0;
    while (a_busy && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle timeout: busy=%b required 0", name, a_busy);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    a_req = '0; a_step = '0; a_len = '0;
    b_req = '0; b_step = '0; b_len = '0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({a_grant, a_done, a_addr, a_valid, a_busy} !== '0) begin
      errors++;
      $display("FAIL reset_a: grant=%b done=%b addr=%0d valid=%b busy=%b required all 0",
               a_grant, a_done, a_addr, a_valid, a_busy);
    end
    checks++;
    if ({b_grant, b_done, b_addr, b_valid, b_busy} !== '0) begin
      errors++;
      $display("FAIL reset_b: grant=%b done=%b addr=%0d valid=%b busy=%b required all 0",
               b_grant, b_done, b_addr, b_valid, b_busy);
    end
    sys_rst = 1'b0;
  endtask

  // One isolated burst on instance A; request and fields are scrambled after the grant edge.
  task automatic a_burst(input int idx, input int step, input int len, input string name);
    logic [N-1:0] oh = N'(1) << idx;
    int n = (len > 0) ? len : 1;
    int exp_addr;
    a_step = {$urandom, $urandom};
    a_len  = {$urandom, $urandom};
    a_step[idx*AW +: AW] = AW'(step);
    a_len[idx*LW +: LW]  = LW'(len);
    a_req = oh;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      if (k == 0) begin
        a_req  = '0;
        a_step = {$urandom, $urandom};
        a_len  = {$urandom, $urandom};
      end
      checks++;
      if (a_grant !== oh || a_valid !== (len != 0) || a_busy !== 1'b1 || a_done !== '0) begin
        errors++;
        $display("FAIL %s k=%0d: grant=%b valid=%b busy=%b done=%b required %b %b 1 0000",
                 name, k, a_grant, a_valid, a_busy, a_done, oh, (len != 0));
      end
      if (len != 0) begin
        exp_addr = (k * step) % (1 << AW);
        checks++;
        if (a_addr !== AW'(exp_addr)) begin
          errors++;
          $display("FAIL %s addr k=%0d: got %0d required %0d", name, k, a_addr, exp_addr);
        end
      end
    end
    @(negedge sys_clk);
    checks++;
    if (a_done !== oh || a_grant !== '0 || a_valid !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s done: done=%b grant=%b valid=%b busy=%b required %b 0000 0 1",
               name, a_done, a_grant, a_valid, a_busy, oh);
    end
`ifdef DDS_SCHED_ABORT_EN
    checks++;
    if (a_aborted !== 1'b0) begin
      errors++;
      $display("FAIL %s aborted: got %b required 0", name, a_aborted);
    end
`endif
    @(negedge sys_clk);
    checks++;
    if (a_done !== '0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s gap2: done=%b busy=%b required 0000 1", name, a_done, a_busy);
    end
    @(negedge sys_clk);
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy=%b required 0", name, a_busy);
    end
  endtask

  task automatic test_single_burst(); a_burst(0, 32, 4, "single"); endtask
  task automatic test_wrap();         a_burst(2, 300, 5, "wrap"); endtask
  task automatic test_len0();         a_burst(1, $urandom_range(1, 1023), 0, "len0"); endtask
  task automatic test_step0();        a_burst(3, 0, 3, "step0"); endtask

  task automatic test_random_bursts();
    for (int t = 0; t < 6; t++)
      a_burst($urandom_range(0, N-1), $urandom_range(0, 1023), $urandom_range(0, 9), "rand");
  endtask

  task automatic test_mid_reset();
    a_step = '0; a_len = '0;
    a_step[2*AW +: AW] = AW'(5);
    a_len[2*LW +: LW]  = LW'(8);
    a_req = 4'b0100;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (a_addr !== AW'(10) || a_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst sample2: addr=%0d valid=%b required 10 1", a_addr, a_valid);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({a_grant, a_done, a_addr, a_valid, a_busy} !== '0) begin
      errors++;
      $display("FAIL midrst outputs: grant=%b done=%b addr=%0d valid=%b busy=%b required all 0",
               a_grant, a_done, a_addr, a_valid, a_busy);
    end
    sys_rst = 1'b0;
    a_req  = 4'b1111;
    a_step = {$urandom, $urandom};
    for (int i = 0; i < N; i++) a_len[i*LW +: LW] = LW'($urandom_range(1, 4));
    @(negedge sys_clk);
    a_req = '0;
    checks++;
    if (a_grant !== 4'b0001) begin
      errors++;
      $display("FAIL midrst priority: grant=%b required 0001", a_grant);
    end
    wait_a_idle("midrst");
  endtask

  // Instance B: arbitration model searches from a bench-kept pointer; bursts are contiguous.
  task automatic test_round_robin();
    int ptr_m = 0;
    int prev  = -1;
    int w;
    int c;
    int exp_addr;
    logic [N-1:0] mask = 4'hF;
    logic [N-1:0] exp_done;
    int lens[N];
    int steps[N];
    for (int i = 0; i < N; i++) begin
      steps[i] = $urandom_range(0, 1023);
      lens[i]  = 2;
      b_step[i*AW +: AW] = AW'(steps[i]);
      b_len[i*LW +: LW]  = LW'(lens[i]);
    end
    b_req = mask;
    for (int b = 0; b < 12; b++) begin
      if (b >= 5) begin
        mask  = N'($urandom_range(1, 15));
        b_req = mask;
        for (int i = 0; i < N; i++) begin
          lens[i] = $urandom_range(1, 4);
          b_len[i*LW +: LW] = LW'(lens[i]);
        end
      end
      w = -1;
      for (int j = 0; j < N; j++) begin
        c = (ptr_m + j) % N;
        if (w < 0 && mask[c]) w = c;
      end
      ptr_m = (w + 1) % N;
      for (int k = 0; k < lens[w]; k++) begin
        @(negedge sys_clk);
        exp_addr = (k * steps[w]) % (1 << AW);
        checks++;
        if (b_grant !== (N'(1) << w) || b_valid !== 1'b1 || b_addr !== AW'(exp_addr)) begin
          errors++;
          $display("FAIL rr burst%0d k=%0d: grant=%b valid=%b addr=%0d required %b 1 %0d",
                   b, k, b_grant, b_valid, b_addr, N'(1) << w, exp_addr);
        end
        if (k == 0) begin
          exp_done = (prev < 0) ? '0 : (N'(1) << prev);
          checks++;
          if (b_done !== exp_done) begin
            errors++;
            $display("FAIL rr done burst%0d: got %b required %b", b, b_done, exp_done);
          end
        end
      end
      prev = w;
    end
    b_req = '0;
    @(negedge sys_clk);
    checks++;
    if (b_done !== (N'(1) << prev) || b_grant !== '0 || b_valid !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL rr final: done=%b grant=%b valid=%b busy=%b required %b 0000 0 0",
               b_done, b_grant, b_valid, b_busy, N'(1) << prev);
    end
  endtask

`ifdef DDS_SCHED_ABORT_EN
  task automatic test_abort();
    int step = $urandom_range(1, 1023);
    a_step = '0; a_len = '0;
    a_step[AW-1:0] = AW'(step);
    a_len[LW-1:0]  = LW'(10);
    a_req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      a_req = '0;
      checks++;
      if (a_valid !== 1'b1 || a_addr !== AW'((k * step) % (1 << AW))) begin
        errors++;
        $display("FAIL abort k=%0d: valid=%b addr=%0d required 1 %0d",
                 k, a_valid, a_addr, (k * step) % (1 << AW));
      end
    end
    a_abort = 1'b1;
    @(negedge sys_clk);
    a_abort = 1'b0;
    checks++;
    if (a_done !== 4'b0001 || a_aborted !== 1'b1 || a_valid !== 1'b0 || a_grant !== '0) begin
      errors++;
      $display("FAIL abort end: done=%b aborted=%b valid=%b grant=%b required 0001 1 0 0000",
               a_done, a_aborted, a_valid, a_grant);
    end
    wait_a_idle("abort");
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_wrap();
    test_len0();
    test_step0();
    test_random_bursts();
    test_mid_reset();
    test_round_robin();
`ifdef DDS_SCHED_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
